ex_core_adder4: RTL and testbench

- Parameterised unsigned/two's-complement adder for the ex_core example datapath. Default width is 4 bits.
- Combinational sum path: sum is valid in the same delta as the a/b inputs change, with no clock required.
- Registered result stage: registered sum, carry, overflow and zero flags with a valid strobe, for pipelined consumers.

---
 rtl/ex_core_adder4.sv | 63 ++++++
 tb/tb_ex_core_adder4.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/ex_core_adder4.sv
// Parameterised adder with a combinational sum and a registered result stage carrying flags.
// Optional subtract mode: define EX_CORE_ADDER_SUB_EN to add the sub_op port.
module ex_core_adder4 #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             Clk,
    input  logic             RstN,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef EX_CORE_ADDER_SUB_EN
    input  logic             sub_op,
`endif
    input  logic             in_valid,
    output logic [WIDTH-1:0] sum,
    output logic [WIDTH-1:0] sum_q,
    output logic             carry_q,
    output logic             ovf_q,
    output logic             zero_q,
    output logic             out_valid
);

    logic [WIDTH-1:0] b_eff;
    logic             carry_in;
    logic [WIDTH:0]   result;
    logic             carry;
    logic             ovf;
    logic             zero;

`ifdef EX_CORE_ADDER_SUB_EN
    // Subtraction as a + ~b + 1; carry-out then reads as no-borrow.
    assign b_eff    = sub_op ? ~b : b;
    assign carry_in = sub_op;
`else
    assign b_eff    = b;
    assign carry_in = 1'b0;
`endif

    assign result = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, carry_in};
    assign sum    = result[WIDTH-1:0];
    assign carry  = result[WIDTH];
    // Using b_eff makes one rule cover both the add and the subtract overflow cases.
    assign ovf    = (a[WIDTH-1] == b_eff[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
    assign zero   = (result[WIDTH-1:0] == '0);

    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            sum_q     <= '0;
            carry_q   <= 1'b0;
            ovf_q     <= 1'b0;
            zero_q    <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                sum_q   <= sum;
                carry_q <= carry;
                ovf_q   <= ovf;
                zero_q  <= zero;
            end
        end
    end

endmodule

// File: tb/tb_ex_core_adder4.sv
// Directed self-checking bench for ex_core_adder4 at WIDTH=4.
// Subtract scenarios are compiled in only when EX_CORE_ADDER_SUB_EN is defined.
module tb_ex_core_adder4;

    logic       Clk;
    logic       RstN;
    logic [3:0] a;
    logic [3:0] b;
    logic       sub_op;
    logic       in_valid;
    logic [3:0] sum;
    logic [3:0] sum_q;
    logic       carry_q;
    logic       ovf_q;
    logic       zero_q;
    logic       out_valid;

    int total;
    int bad;

    ex_core_adder4 #(.WIDTH(4)) dut (
        .Clk      (Clk),
        .RstN     (RstN),
        .a        (a),
        .b        (b),
`ifdef EX_CORE_ADDER_SUB_EN
        .sub_op   (sub_op),
`endif
        .in_valid (in_valid),
        .sum      (sum),
        .sum_q    (sum_q),
        .carry_q  (carry_q),
        .ovf_q    (ovf_q),
        .zero_q   (zero_q),
        .out_valid(out_valid)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Registered outputs packed as {sum_q, carry_q, ovf_q, zero_q, out_valid}.
    function automatic logic [7:0] regs();
        return {sum_q, carry_q, ovf_q, zero_q, out_valid};
    endfunction

    task automatic test_reset();
        RstN     = 1'b0;
        a        = 4'h1;
        b        = 4'h3;
        sub_op   = 1'b0;
        in_valid = 1'b0;
        #10;
        total++;
        if (sum !== 4'h4) begin
            bad++;
            $display("FAIL reset_comb_sum: got %h want 4", sum);
        end
        total++;
        if (regs() !== 8'h00) begin
            bad++;
            $display("FAIL reset_regs: got %b want 00000000", regs());
        end
    endtask

    task automatic test_capture();
        @(negedge Clk);
        RstN     = 1'b1;
        a        = 4'h7;
        b        = 4'h1;
        in_valid = 1'b1;
        @(posedge Clk);
        #1;
        total++;
        if (regs() !== {4'h8, 1'b0, 1'b1, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL capture_7p1: got %b want 10000101", regs());
        end
        @(negedge Clk);
        in_valid = 1'b0;
        a        = 4'h2;
        @(posedge Clk);
        #1;
        total++;
        if (regs() !== {4'h8, 1'b0, 1'b1, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL capture_hold: got %b want 10000100", regs());
        end
    endtask

    task automatic test_wrap();
        @(negedge Clk);
        a        = 4'h8;
        b        = 4'h8;
        in_valid = 1'b1;
        #1;
        total++;
        if (sum !== 4'h0) begin
            bad++;
            $display("FAIL wrap_comb_sum: got %h want 0", sum);
        end
        @(posedge Clk);
        #1;
        total++;
        if (regs() !== {4'h0, 1'b1, 1'b1, 1'b1, 1'b1}) begin
            bad++;
            $display("FAIL wrap_regs: got %b want 00001111", regs());
        end
        @(negedge Clk);
        in_valid = 1'b0;
        @(posedge Clk);
        #1;
        total++;
        if (out_valid !== 1'b0 || zero_q !== 1'b1) begin
            bad++;
            $display("FAIL wrap_strobe: got valid=%b zero=%b want valid=0 zero=1",
                     out_valid, zero_q);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] va [3] = '{4'h2, 4'hF, 4'h5};
        logic [3:0] vb [3] = '{4'h2, 4'h1, 4'hA};
        logic [3:0] vs [3] = '{4'h4, 4'h0, 4'hF};
        logic       vc [3] = '{1'b0, 1'b1, 1'b0};
        logic       vz [3] = '{1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            a        = va[i];
            b        = vb[i];
            in_valid = 1'b1;
            @(posedge Clk);
            #1;
            total++;
            if (sum_q !== vs[i] || carry_q !== vc[i] || zero_q !== vz[i] ||
                ovf_q !== 1'b0 || out_valid !== 1'b1) begin
                bad++;
                $display("FAIL b2b_%0d: got sum_q=%h c=%b v=%b z=%b ov=%b want %h %b 0 %b 1",
                         i, sum_q, carry_q, ovf_q, zero_q, out_valid, vs[i], vc[i], vz[i]);
            end
        end
    endtask

    task automatic test_async_reset();
        // Entered just after an edge with out_valid=1 and sum_q=F.
        #2;
        RstN = 1'b0;
        #1;
        total++;
        if (regs() !== 8'h00) begin
            bad++;
            $display("FAIL async_reset_regs: got %b want 00000000", regs());
        end
        total++;
        if (sum !== 4'hF) begin
            bad++;
            $display("FAIL async_reset_sum: got %h want f", sum);
        end
        @(negedge Clk);
        a        = 4'h1;
        b        = 4'h1;
        in_valid = 1'b1;
        RstN     = 1'b1;
        @(posedge Clk);
        #1;
        total++;
        if (regs() !== {4'h2, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL release_capture: got %b want 00100001", regs());
        end
        @(negedge Clk);
        in_valid = 1'b0;
    endtask

`ifdef EX_CORE_ADDER_SUB_EN
    task automatic test_sub();
        @(negedge Clk);
        sub_op   = 1'b1;
        a        = 4'h3;
        b        = 4'h5;
        in_valid = 1'b1;
        #1;
        total++;
        if (sum !== 4'hE) begin
            bad++;
            $display("FAIL sub_comb_3m5: got %h want e", sum);
        end
        @(posedge Clk);
        #1;
        total++;
        if (regs() !== {4'hE, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL sub_regs_3m5: got %b want 11100001", regs());
        end
        @(negedge Clk);
        a = 4'h5;
        b = 4'h3;
        @(posedge Clk);
        #1;
        total++;
        if (regs() !== {4'h2, 1'b1, 1'b0, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL sub_regs_5m3: got %b want 00101001", regs());
        end
        @(negedge Clk);
        sub_op   = 1'b0;
        in_valid = 1'b0;
    endtask
`endif

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_capture();
        test_wrap();
        test_back_to_back();
        test_async_reset();
`ifdef EX_CORE_ADDER_SUB_EN
        test_sub();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
